sram_controller: RTL
====================

# sram_controller

Single-clock SRAM access controller for the 256K×16 asynchronous framebuffer SRAM. It is the responder side of the framebuffer's SRAM interface. It arbitrates a VGA-scanout read port against a dot-draw write port and turns each accepted request into a fixed-length, glitch-free CE/OE/WE sequence on the chip pins. It also returns read data with a fixed latency.

## Interface
- `WR_STARVE_MAX`, 8 — consecutive lost arbitrations a pending write tolerates before it wins once; legal range 1–15.
- `SRAMClk` input 1 — controller clock, 50 MHz; all logic on the rising edge.
- `Reset_n` input 1 — synchronous, active-low reset.
- `rdReq` input 1 — read request; held high, with `rdAddr` stable, until `rdGrant` is seen.
- `rdAddr` input 18 — read word address.
- `rdGrant` output 1 — one-cycle pulse: read accepted.
- `rdData` output 16 — read data; valid while `rdValid` is high, held otherwise.
- `rdValid` output 1 — one-cycle pulse: `rdData` is valid.
- `wrReq` input 1 — write request; held high, with `wrAddr`, `wrData` and `wrByteEn` stable, until `wrGrant` is seen.
- `wrAddr` input 18 — write word address.
- `wrData` input 16 — write data.
- `wrByteEn` input 2 — bit1 = upper byte, bit0 = lower byte. The port exists only with `SRAM_BYTE_ENABLE_EN`.
- `wrGrant` output 1 — one-cycle pulse: write accepted.
- `SRAM_ADDR` output 18 — chip address.
- `SRAM_DQ` inout 16 — chip data; high-Z except during write states.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each — active-low chip controls.

## Operation
- **Registered outputs:** every chip pin and every handshake output is driven from a flop; there are no combinational paths to pins.
- **IDLE**
  - Pins: CE_N=OE_N=WE_N=UB_N=LB_N=1; DQ is high-Z.
  - A request sampled at an edge is accepted at that edge: address and data are latched, and the next cycle carries the grant pulse and the first access state.
- **Arbitration** (IDLE only)
  - Read only pending → read wins; write only pending → write wins.
  - Both pending → read wins and `starveCnt` increments, unless `starveCnt == WR_STARVE_MAX`; then write wins.
  - `starveCnt` is 4 bits and clears whenever a write is granted.
- **Read sequence: RD_ACCESS → RD_SAMPLE → IDLE**
  - Both states: CE_N=0, OE_N=0, UB_N=LB_N=0, SRAM_ADDR = latched address.
  - At the edge leaving RD_SAMPLE: `SRAM_DQ` is captured into `rdData` and `rdValid` is set for one cycle.
- **Write sequence: WR_SETUP → WR_PULSE → WR_HOLD → IDLE**
  - All three states: CE_N=0, address stable, DQ driven with the latched data.
  - WE_N=0 only in WR_PULSE.
  - Data is driven one cycle before and one cycle after the WE pulse (setup/hold margin).
  - OE_N=1 throughout.
- **Requester rule:** a new request, or a change to the request fields, is legal only after the grant has been observed.
- **Reset mid-operation:** the FSM goes to IDLE. All controls go to 1, DQ goes high-Z, grants and `rdValid` go to 0, `starveCnt` goes to 0. An in-flight read produces no `rdValid`; an in-flight write is abandoned, and the target word is undefined.

## Timing
- **Reset values:** `rdGrant`=0, `wrGrant`=0, `rdValid`=0, `rdData`=0, `SRAM_ADDR`=0, all `SRAM_*_N`=1, DQ high-Z.
- **Read:** accept at edge E0. `rdGrant` is high in [E0,E1); `rdValid` and `rdData` are valid in [E2,E3). Read-to-read throughput is one read per 3 cycles.
- **Write:** accept at E0. `wrGrant` is high in [E0,E1); WE_N is low in [E1,E2); back in IDLE in [E3,E4). Write throughput is one write per 4 cycles.
- **Back-to-back:** the earliest next accept is the edge ending the first IDLE cycle after a sequence; there is never a gap with pins active between operations.
- **Simultaneous requests:** at most one grant per accept; `rdGrant` and `wrGrant` are never high together.

## Configuration
- `SRAM_BYTE_ENABLE_EN` defined:
  - The `wrByteEn` port exists.
  - During write states, UB_N = ~`wrByteEn`[1] and LB_N = ~`wrByteEn`[0], using the latched values.
  - `wrByteEn`=2'b00 still runs the full write sequence with both strobes high, so no byte is written.
- Undefined: no `wrByteEn` port; UB_N=LB_N=0 during all writes.
- Reads always use UB_N=LB_N=0 in both builds.

## Test plan
- **Reset:** hold `Reset_n`=0 for 2 cycles → all `SRAM_*_N`=1, DQ high-Z, grants, `rdValid` and `rdData` = 0.
- **Single read:** `rdReq`, `rdAddr`=18'h12345, SRAM model word 16'hBEEF → `rdGrant` for 1 cycle. OE_N/CE_N are low for exactly 2 cycles; `rdValid` arrives 2 cycles after grant with `rdData`=16'hBEEF.
- **Single write:** `wrAddr`=18'h00320, `wrData`=16'h7C1F → WE_N is low for exactly 1 cycle, with DQ=16'h7C1F one cycle before through one cycle after; a later read of 18'h00320 returns 16'h7C1F.
- **Starvation:** `rdReq` and `wrReq` held continuously, `WR_STARVE_MAX`=8 → 8 read grants, then 1 write grant, then reads resume; the grant pattern repeats.
- **Reset mid-read:** assert reset in RD_SAMPLE → no `rdValid`, IDLE next cycle, a subsequent read completes normally.
- **Byte enable** (`SRAM_BYTE_ENABLE_EN`): word 16'hFFFF, write 16'h1234 with `wrByteEn`=2'b01 → readback is 16'hFF34.

Source files
------------

// File: rtl/sram_controller.sv
// SRAM access controller for the 256Kx16 framebuffer: arbitrates scanout reads against dot-draw
// writes and sequences CE/OE/WE from flops. Optional per-byte write strobes under SRAM_BYTE_ENABLE_EN.
module sram_controller #(
  parameter int WR_STARVE_MAX = 8
) (
  input  logic        SRAMClk,
  input  logic        Reset_n,
  input  logic        rdReq,
  input  logic [17:0] rdAddr,
  output logic        rdGrant,
  output logic [15:0] rdData,
  output logic        rdValid,
  input  logic        wrReq,
  input  logic [17:0] wrAddr,
  input  logic [15:0] wrData,
`ifdef SRAM_BYTE_ENABLE_EN
  input  logic [1:0]  wrByteEn,
`endif
  output logic        wrGrant,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE, RD_ACCESS, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(WR_STARVE_MAX);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [15:0] dq_out;
  logic        dq_oe;

  // Write data is driven from WR_SETUP through WR_HOLD, bracketing the WE pulse.
  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge SRAMClk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      rdGrant    <= 1'b0;
      wrGrant    <= 1'b0;
      rdValid    <= 1'b0;
      rdData     <= 16'h0000;
      SRAM_ADDR  <= 18'h0;
      dq_out     <= 16'h0000;
      dq_oe      <= 1'b0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
    end else begin
      rdGrant <= 1'b0;
      wrGrant <= 1'b0;
      rdValid <= 1'b0;
      case (state)
        IDLE: begin
          // A starved write wins exactly once when the counter hits the limit.
          if (rdReq && !(wrReq && starve_cnt == STARVE_LIM)) begin
            state     <= RD_ACCESS;
            rdGrant   <= 1'b1;
            SRAM_ADDR <= rdAddr;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            if (wrReq) starve_cnt <= starve_cnt + 4'd1;
          end else if (wrReq) begin
            state      <= WR_SETUP;
            wrGrant    <= 1'b1;
            starve_cnt <= 4'd0;
            SRAM_ADDR  <= wrAddr;
            dq_out     <= wrData;
            dq_oe      <= 1'b1;
            SRAM_CE_N  <= 1'b0;
`ifdef SRAM_BYTE_ENABLE_EN
            SRAM_UB_N  <= ~wrByteEn[1];
            SRAM_LB_N  <= ~wrByteEn[0];
`else
            SRAM_UB_N  <= 1'b0;
            SRAM_LB_N  <= 1'b0;
`endif
          end
        end
        RD_ACCESS: state <= RD_SAMPLE;
        RD_SAMPLE: begin
          state     <= IDLE;
          rdData    <= SRAM_DQ;
          rdValid   <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          SRAM_WE_N <= 1'b0;
        end
        WR_PULSE: begin
          state     <= WR_HOLD;
          SRAM_WE_N <= 1'b1;
        end
        WR_HOLD: begin
          state     <= IDLE;
          dq_oe     <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
